// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, branch
// opcode and PC defaults. Optional macro: FETCH_MISALIGN_TRAP_EN adds S_TRAP.
package fetch_pkg;

  localparam logic [6:0]  OPC_BRANCH       = 7'h63;
  localparam int unsigned PC_INC_DEFAULT   = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
    S_HOLD = 2'd2,
    S_TRAP = 2'd3
`else
    S_HOLD = 2'd2
`endif
  } fetch_state_e;

  function automatic logic is_branch(input logic [6:0] opcode);
    return opcode == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: taken branch adds the signed offset,
// everything else advances by PC_INC. All arithmetic wraps modulo 2^32.
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int unsigned PC_INC = PC_INC_DEFAULT
) (
  input  logic [31:0] i_pc,
  input  logic [6:0]  i_opcode,
  input  logic [31:0] i_pcbr,
  output logic [31:0] o_next_pc
);

  localparam logic [31:0] INC = 32'(PC_INC);

  // A zero offset doubles as "not taken", so it falls through to sequential.
  always_comb begin
    o_next_pc = i_pc + INC;
    if (is_branch(i_opcode) && (i_pcbr != 32'h0)) begin
      o_next_pc = i_pc + i_pcbr;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: requests one word per fetch, holds it for decode,
// then advances the PC. Optional macro: FETCH_MISALIGN_TRAP_EN.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_INC   = PC_INC_DEFAULT
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic [31:0] oIMEM_ADDR,
  output logic        oIMEM_REQ,
  input  logic        iIMEM_ACK,
  input  logic [31:0] iIMEM_DATA,
  output logic [31:0] oIR,
  output logic [31:0] oPC,
  output logic        oIR_VALID,
  input  logic        iIR_READY,
  input  logic [31:0] iPCBR,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        oMISALIGN,
`endif
  output logic [1:0]  oDBG_STATE
);

  // Handshakes: memory side transfers when oIMEM_REQ && iIMEM_ACK in S_REQ
  // (REQ/ADDR held until then); decode side transfers when oIR_VALID &&
  // iIR_READY, and oIR/oPC are held stable while oIR_VALID waits for ready.

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_imem_addr;
  logic         r_imem_req;
  logic [31:0]  r_ir;
  logic [31:0]  r_ir_pc;
  logic         r_ir_valid;
  logic [31:0]  w_next_pc_raw;
  logic [31:0]  w_next_pc;

  pc_next_calc #(
    .PC_INC (PC_INC)
  ) u_pc_next_calc (
    .i_pc      (r_ir_pc),
    .i_opcode  (r_ir[6:0]),
    .i_pcbr    (iPCBR),
    .o_next_pc (w_next_pc_raw)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misaligned;

  assign w_next_pc    = w_next_pc_raw;
  assign w_misaligned = |w_next_pc_raw[1:0];
  assign oMISALIGN    = r_misalign;
`else
  // Without the trap, the low bits are dropped so fetches stay word aligned.
  assign w_next_pc = w_next_pc_raw & ~32'h3;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_imem_addr <= 32'h0;
      r_imem_req  <= 1'b0;
      r_ir        <= 32'h0;
      r_ir_pc     <= 32'h0;
      r_ir_valid  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= S_REQ;
          r_imem_req  <= 1'b1;
          r_imem_addr <= r_pc;
        end
        S_REQ: begin
          if (iIMEM_ACK) begin
            r_state    <= S_HOLD;
            r_imem_req <= 1'b0;
            r_ir       <= iIMEM_DATA;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (iIR_READY) begin
            r_pc       <= w_next_pc;
            r_ir_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_misaligned) begin
              r_state    <= S_TRAP;
              r_misalign <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_next_pc;
            end
`else
            r_state     <= S_REQ;
            r_imem_req  <= 1'b1;
            r_imem_addr <= w_next_pc;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        // Sticky until reset: no requests, no valid instruction.
        S_TRAP: begin
          r_imem_req <= 1'b0;
          r_ir_valid <= 1'b0;
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oIMEM_ADDR = r_imem_addr;
  assign oIMEM_REQ  = r_imem_req;
  assign oIR        = r_ir;
  assign oPC        = r_ir_pc;
  assign oIR_VALID  = r_ir_valid;
  assign oDBG_STATE = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, branches, stalls,
// wrap-around, reset abort and misalignment (FETCH_MISALIGN_TRAP_EN aware).
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] BEQ = 32'h0020_8463;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        iCLK;
  logic        iRST;
  logic [31:0] oIMEM_ADDR;
  logic        oIMEM_REQ;
  logic        iIMEM_ACK;
  logic [31:0] iIMEM_DATA;
  logic [31:0] oIR;
  logic [31:0] oPC;
  logic        oIR_VALID;
  logic        iIR_READY;
  logic [31:0] iPCBR;
  logic [1:0]  oDBG_STATE;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        oMISALIGN;
`endif

  int n_total;
  int n_bad;
  logic [31:0] exp_q[$];

  instruction_fetch dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .oIMEM_ADDR (oIMEM_ADDR),
    .oIMEM_REQ  (oIMEM_REQ),
    .iIMEM_ACK  (iIMEM_ACK),
    .iIMEM_DATA (iIMEM_DATA),
    .oIR        (oIR),
    .oPC        (oPC),
    .oIR_VALID  (oIR_VALID),
    .iIR_READY  (iIR_READY),
    .iPCBR      (iPCBR),
`ifdef FETCH_MISALIGN_TRAP_EN
    .oMISALIGN  (oMISALIGN),
`endif
    .oDBG_STATE (oDBG_STATE)
  );

  // clock / reset
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // From a REQ cycle at exp_pc: deliver data, then accept it with pcbr and
  // confirm the next request address. iPCBR carries junk outside accept.
  task automatic do_fetch(input logic [31:0] data, input logic [31:0] pcbr,
                          input logic [31:0] exp_pc, input logic [31:0] exp_next);
    chk("req_addr", oIMEM_ADDR, exp_pc);
    chk("req_hi", 32'(oIMEM_REQ), 32'h1);
    iIMEM_ACK  = 1'b1;
    iIMEM_DATA = data;
    iIR_READY  = 1'b0;
    iPCBR      = 32'h0000_0006;
    tick();
    chk("hold_ir", oIR, data);
    chk("hold_pc", oPC, exp_pc);
    chk("hold_valid", 32'(oIR_VALID), 32'h1);
    iIMEM_ACK = 1'b0;
    iIR_READY = 1'b1;
    iPCBR     = pcbr;
    tick();
    chk("next_addr", oIMEM_ADDR, exp_next);
    chk("next_req", 32'(oIMEM_REQ), 32'h1);
    chk("next_valid", 32'(oIR_VALID), 32'h0);
    iIR_READY = 1'b0;
    iPCBR     = 32'($urandom_range(1, 255)) << 2;
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    iRST       = 1'b1;
    iIMEM_ACK  = 1'b0;
    iIMEM_DATA = 32'h0;
    iIR_READY  = 1'b0;
    iPCBR      = 32'h0;
    tick();
    tick();
    chk("rst_req", 32'(oIMEM_REQ), 32'h0);
    chk("rst_valid", 32'(oIR_VALID), 32'h0);
    chk("rst_ir", oIR, 32'h0);
    chk("rst_pc", oPC, 32'h0);
    chk("rst_addr", oIMEM_ADDR, 32'h0);
    chk("rst_state", 32'(oDBG_STATE), 32'(S_IDLE));

    // Streaming with ACK tied high and READY high: addresses 0,4,8.
    exp_q = {32'h0, 32'h4, 32'h8};
    iRST       = 1'b0;
    iIMEM_ACK  = 1'b1;
    iIMEM_DATA = NOP;
    iIR_READY  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stream_valid", 32'(oIR_VALID), 32'(c % 2));
      chk("stream_req", 32'(oIMEM_REQ), 32'((c + 1) % 2));
      if (oIMEM_REQ && exp_q.size() > 0) chk("stream_addr", oIMEM_ADDR, exp_q.pop_front());
    end
    chk("stream_all_seen", 32'(exp_q.size()), 32'h0);
    iIMEM_ACK = 1'b0;
    iIR_READY = 1'b0;

    // Branch cases around 0x100 and 0x200.
    do_fetch(BEQ, 32'h0000_00F8, 32'h8,   32'h100);
    do_fetch(BEQ, 32'h0000_0008, 32'h100, 32'h108);
    do_fetch(BEQ, 32'hFFFF_FFF8, 32'h108, 32'h100);
    do_fetch(BEQ, 32'h0000_0000, 32'h100, 32'h104);
    do_fetch(BEQ, 32'h0000_00FC, 32'h104, 32'h200);
    do_fetch(BEQ, 32'hFFFF_FFF0, 32'h200, 32'h1F0);
    do_fetch(BEQ, 32'h0000_0010, 32'h1F0, 32'h200);
    do_fetch(NOP, 32'h0000_0008, 32'h200, 32'h204);

    // Backpressure, with a stray ACK during HOLD that must be ignored.
    iIMEM_ACK  = 1'b1;
    iIMEM_DATA = NOP;
    tick();
    iIMEM_DATA = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_ir", oIR, NOP);
      chk("bp_pc", oPC, 32'h204);
      chk("bp_req", 32'(oIMEM_REQ), 32'h0);
      chk("bp_valid", 32'(oIR_VALID), 32'h1);
    end
    iIMEM_ACK = 1'b0;
    iIR_READY = 1'b1;
    iPCBR     = 32'h0;
    tick();
    iIR_READY = 1'b0;
    chk("bp_next_addr", oIMEM_ADDR, 32'h208);

    // Wait states: ACK withheld for three cycles.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("ws_addr", oIMEM_ADDR, 32'h208);
      chk("ws_req", 32'(oIMEM_REQ), 32'h1);
    end
    do_fetch(NOP, 32'h0, 32'h208, 32'h20C);

    // Wrap-around through 0xFFFFFFFC.
    do_fetch(BEQ, 32'hFFFF_FDF0, 32'h20C, 32'hFFFF_FFFC);
    do_fetch(NOP, 32'h0, 32'hFFFF_FFFC, 32'h0);

    // Reset abandons a pending request; a late ACK is ignored.
    do_fetch(BEQ, 32'h0000_0040, 32'h0, 32'h40);
    tick();
    iRST = 1'b1;
    tick();
    chk("abort_req", 32'(oIMEM_REQ), 32'h0);
    chk("abort_state", 32'(oDBG_STATE), 32'(S_IDLE));
    iRST       = 1'b0;
    iIMEM_ACK  = 1'b1;
    iIMEM_DATA = 32'hBAD0_0BAD;
    tick();
    iIMEM_ACK = 1'b0;
    chk("late_ack_ir", oIR, 32'h0);
    chk("late_ack_valid", 32'(oIR_VALID), 32'h0);
    chk("restart_state", 32'(oDBG_STATE), 32'(S_REQ));
    do_fetch(BEQ, 32'h0000_0100, 32'h0, 32'h100);

    // Misaligned branch target from 0x100.
`ifdef FETCH_MISALIGN_TRAP_EN
    iIMEM_ACK  = 1'b1;
    iIMEM_DATA = BEQ;
    tick();
    iIMEM_ACK = 1'b0;
    iIR_READY = 1'b1;
    iPCBR     = 32'h2;
    tick();
    chk("trap_flag", 32'(oMISALIGN), 32'h1);
    chk("trap_state", 32'(oDBG_STATE), 32'(S_TRAP));
    iIMEM_ACK = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("trap_req", 32'(oIMEM_REQ), 32'h0);
      chk("trap_valid", 32'(oIR_VALID), 32'h0);
    end
    iIMEM_ACK = 1'b0;
`else
    do_fetch(BEQ, 32'h0000_0002, 32'h100, 32'h100);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter PC_INC, default 4: sequential PC increment in bytes.
REQ-003 iCLK  input  1  single clock; all state updates on posedge iCLK.
REQ-004 iRST  input  1  synchronous, active-high reset, sampled on posedge iCLK.
REQ-005 oIMEM_ADDR  output  32  fetch address presented to instruction memory.
REQ-006 oIMEM_REQ  output  1  fetch request, held high until acknowledged.
REQ-007 iIMEM_ACK  input  1  memory acknowledge; iIMEM_DATA is valid in the same cycle.
REQ-008 iIMEM_DATA  input  32  fetched instruction word.
REQ-009 oIR  output  32  registered instruction, fed to the decode and branch stages.
REQ-010 oPC  output  32  address of the instruction currently in oIR.
REQ-011 oIR_VALID  output  1  oIR/oPC hold a valid instruction.
REQ-012 iIR_READY  input  1  downstream consumes oIR this cycle.
REQ-013 iPCBR  input  32  branch offset from the branch stage; 32'h0 = not taken, otherwise signed byte offset.
REQ-014 oMISALIGN  output  1  misaligned next-PC trap flag; present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-015 FSM states: S_IDLE, S_REQ, S_HOLD, plus S_TRAP with FETCH_MISALIGN_TRAP_EN.
REQ-016 S_IDLE: all outputs low; unconditional transition to S_REQ on the next cycle.
REQ-017 S_REQ: oIMEM_REQ=1 and oIMEM_ADDR=PC; oIMEM_ADDR stays stable while waiting for iIMEM_ACK.
REQ-018 On iIMEM_ACK in S_REQ: oIR<=iIMEM_DATA, oPC<=PC, go to S_HOLD; an ACK arriving in the same cycle as the request is legal (minimum 1 cycle per fetch).
REQ-019 iIMEM_ACK outside S_REQ is ignored.
REQ-020 S_HOLD: oIR_VALID=1 and oIMEM_REQ=0; oIR and oPC stay stable until iIR_READY.
REQ-021 Accepting an instruction (S_HOLD with iIR_READY=1) updates PC and sets the next state to S_REQ.
REQ-022 If oIR[6:0]==7'h63 and iPCBR!=0, next PC = oPC + iPCBR; otherwise next PC = oPC + PC_INC.
REQ-023 iPCBR is sampled only at accept; its value at any other time has no effect.
REQ-024 All PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0, with no overflow flag.
REQ-025 Fetch throughput: at most one instruction per 2 cycles (a REQ cycle followed by a HOLD cycle).

Reset
REQ-026 When iRST=1 at a clock edge: state<=S_IDLE, PC<=RESET_PC, oIR<=0, oPC<=0, oIR_VALID<=0, oIMEM_REQ<=0, oMISALIGN<=0.
REQ-027 Reset asserted mid-fetch abandons the outstanding request; an ACK arriving after reset is ignored.
REQ-028 The first oIMEM_REQ appears 1 cycle after iRST deasserts (the S_IDLE cycle), with oIMEM_ADDR=RESET_PC.

Configuration
REQ-029 Macro FETCH_MISALIGN_TRAP_EN.
REQ-030 Defined: if next PC[1:0]!=0 at accept, go to S_TRAP with oMISALIGN=1, no requests, oIR_VALID=0; the block leaves S_TRAP only on reset.
REQ-031 Not defined: next PC[1:0] is forced to 2'b00, oMISALIGN is absent, and S_TRAP does not exist.

Structure
REQ-032 Shared package fetch_pkg holds: the state enum encoding, OPC_BRANCH=7'h63, PC_INC default, and RESET_PC default.
REQ-033 Sub-module pc_next_calc (combinational) takes oPC, oIR opcode and iPCBR, and produces next PC; it contains no other logic.

Verification
REQ-034 Reset then release with ACK tied high: first request has oIMEM_ADDR=0x0; IR_VALID pulses every 2 cycles with READY=1; addresses 0x0, 0x4, 0x8.
REQ-035 Branch: oPC=0x100, oIR=0x00208463 (beq), iPCBR=0x8 at accept -> next oIMEM_ADDR=0x108; same with iPCBR=0 -> 0x104.
REQ-036 Backward branch: oPC=0x200, branch opcode, iPCBR=0xFFFFFFF0 -> next address 0x1F0; non-branch opcode 0x00000013 with iPCBR=0x8 -> 0x204.
REQ-037 Backpressure and wait states: READY low for 5 cycles -> oIR and oPC unchanged, REQ low; ACK delayed 3 cycles -> oIMEM_ADDR stable and REQ held high.
REQ-038 Reset while REQ is pending, then a late ACK -> ignored; fetch restarts at RESET_PC. Wrap-around: PC=0xFFFFFFFC -> next 0x0.
REQ-039 With FETCH_MISALIGN_TRAP_EN: branch with iPCBR=0x2 from 0x100 -> oMISALIGN=1 and no further REQ; without the macro -> next address 0x100.
